// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen : program-counter generator for the RV32 fetch stage.
//
// Produces the registered fetch PC and its instruction-memory word address.
// Redirects are resolved by priority: reset, trap, execute jump (aligned or
// rejected as misaligned), stall, return-address-stack pop, then sequential.
// The return-address stack (RAS) is circular: a push when it is full
// overwrites the oldest entry.
//
// Parameters
//   XLEN       PC width in bits
//   RESET_VEC  PC loaded on reset (low 2 bits must be 0)
//   MEM_AW     instruction-memory word-address width
//   RAS_DEPTH  RAS entries (power of two, >= 2)
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall             hold the PC
//   trapEn/trapVect   trap redirect (trapVect[1:0] forced to 0)
//   jumpEn/jumpVect   execute-resolved branch/jump redirect
//   callEn/linkAddr   push linkAddr onto the RAS
//   retEn             predict a return from the RAS top
//   pc                registered fetch PC
//   pcForMem          pc[MEM_AW+1:2], word address for instruction memory
//   enA               memory enable (combinational)
//   misalignErr       one-cycle pulse on a rejected jump
//   misalignAddr      last rejected jumpVect
//   rasUnderflow      one-cycle pulse on a pop from an empty RAS
//   rasCount          number of valid RAS entries
// -----------------------------------------------------------------------------
module pc_gen #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_VEC = '0,
    parameter int               MEM_AW    = 13,
    parameter int               RAS_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        trapEn,
    input  logic [XLEN-1:0]             trapVect,
    input  logic                        jumpEn,
    input  logic [XLEN-1:0]             jumpVect,
    input  logic                        callEn,
    input  logic [XLEN-1:0]             linkAddr,
    input  logic                        retEn,
    output logic [XLEN-1:0]             pc,
    output logic [MEM_AW-1:0]           pcForMem,
    output logic                        enA,
    output logic                        misalignErr,
    output logic [XLEN-1:0]             misalignAddr,
    output logic                        rasUnderflow,
    output logic [$clog2(RAS_DEPTH):0]  rasCount
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    // One action per cycle, chosen by the redirect priority (reset is handled
    // directly in the register process and always wins).
    typedef enum logic [2:0] {
        ACT_TRAP,
        ACT_JUMP,
        ACT_MISALIGN,
        ACT_STALL,
        ACT_POP,
        ACT_UNDERFLOW,
        ACT_SEQ
    } action_e;

    // State
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_wptr;            // next slot to write
    logic [CNT_W-1:0] r_count;
    logic             r_misalign_err;
    logic [XLEN-1:0]  r_misalign_addr;
    logic             r_ras_underflow;

    // Next-state / datapath
    action_e          w_act;
    logic [XLEN-1:0]  w_pc_plus4;
    logic [PTR_W-1:0] w_top_ptr;
    logic [XLEN-1:0]  w_top;
    logic [CNT_W-1:0] w_push_count;
    logic [XLEN-1:0]  w_pc_next;
    logic [PTR_W-1:0] w_wptr_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_ras_we;
    logic [PTR_W-1:0] w_ras_waddr;
    logic             w_misalign_err_next;
    logic [XLEN-1:0]  w_misalign_addr_next;
    logic             w_ras_underflow_next;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_pc_plus4           = r_pc + XLEN'(4);   // wraps modulo 2^XLEN
        w_top_ptr            = r_wptr - PTR_W'(1);
        w_top                = r_ras[w_top_ptr];
        w_push_count         = (r_count == FULL_CNT) ? r_count : r_count + CNT_W'(1);

        w_pc_next            = r_pc;
        w_wptr_next          = r_wptr;
        w_count_next         = r_count;
        w_ras_we             = 1'b0;
        w_ras_waddr          = r_wptr;
        w_misalign_err_next  = 1'b0;
        w_misalign_addr_next = r_misalign_addr;
        w_ras_underflow_next = 1'b0;

        if (trapEn) begin
            w_act = ACT_TRAP;
        end else if (jumpEn && (jumpVect[1:0] == 2'b00)) begin
            w_act = ACT_JUMP;
        end else if (jumpEn) begin
            w_act = ACT_MISALIGN;
        end else if (stall) begin
            w_act = ACT_STALL;
        end else if (retEn && (r_count != '0)) begin
            w_act = ACT_POP;
        end else if (retEn) begin
            w_act = ACT_UNDERFLOW;
        end else begin
            w_act = ACT_SEQ;
        end

        unique case (w_act)
            ACT_TRAP: begin
                w_pc_next    = {trapVect[XLEN-1:2], 2'b00};
                w_count_next = '0;               // flush; count alone marks validity
            end
            ACT_JUMP: begin
                w_pc_next = jumpVect;
                if (callEn) begin                // JAL/JALR link; retEn is squashed
                    w_ras_we     = 1'b1;
                    w_wptr_next  = r_wptr + PTR_W'(1);
                    w_count_next = w_push_count;
                end
            end
            ACT_MISALIGN: begin
                w_misalign_err_next  = 1'b1;
                w_misalign_addr_next = jumpVect;
            end
            ACT_STALL: begin
                // PC and RAS hold
            end
            ACT_POP: begin
                w_pc_next = w_top;
                if (callEn) begin
                    // Pop and push in the same cycle: reuse the popped slot.
                    w_ras_we    = 1'b1;
                    w_ras_waddr = w_top_ptr;
                end else begin
                    w_wptr_next  = w_top_ptr;
                    w_count_next = r_count - CNT_W'(1);
                end
            end
            ACT_UNDERFLOW, ACT_SEQ: begin
                w_pc_next            = w_pc_plus4;
                w_ras_underflow_next = (w_act == ACT_UNDERFLOW);
                if (callEn) begin
                    w_ras_we     = 1'b1;
                    w_wptr_next  = r_wptr + PTR_W'(1);
                    w_count_next = w_push_count;
                end
            end
            default: begin
                // unreachable
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc            <= RESET_VEC;
            r_wptr          <= '0;
            r_count         <= '0;
            r_misalign_err  <= 1'b0;
            r_misalign_addr <= '0;
            r_ras_underflow <= 1'b0;
        end else begin
            r_pc            <= w_pc_next;
            r_wptr          <= w_wptr_next;
            r_count         <= w_count_next;
            r_misalign_err  <= w_misalign_err_next;
            r_misalign_addr <= w_misalign_addr_next;
            r_ras_underflow <= w_ras_underflow_next;
        end
    end

    // NOTE: the RAS storage has no reset; r_count marks which entries are
    // valid, so the array maps onto plain registers/RAM without a reset tree.
    always_ff @(posedge clk) begin
        if (w_ras_we && !reset) begin
            r_ras[w_ras_waddr] <= linkAddr;
        end
    end

    assign pc           = r_pc;
    assign pcForMem     = r_pc[MEM_AW+1:2];
    assign enA          = !reset && (!stall || trapEn || jumpEn);
    assign misalignErr  = r_misalign_err;
    assign misalignAddr = r_misalign_addr;
    assign rasUnderflow = r_ras_underflow;
    assign rasCount     = r_count;

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen : directed self-checking bench for pc_gen
// (RESET_VEC = 0x100, RAS_DEPTH = 4, MEM_AW = 13).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each step() shows the effect of exactly one clock edge.
// -----------------------------------------------------------------------------
module tb_pc_gen;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic            trapEn;
    logic [XLEN-1:0] trapVect;
    logic            jumpEn;
    logic [XLEN-1:0] jumpVect;
    logic            callEn;
    logic [XLEN-1:0] linkAddr;
    logic            retEn;
    logic [XLEN-1:0] pc;
    logic [12:0]     pcForMem;
    logic            enA;
    logic            misalignErr;
    logic [XLEN-1:0] misalignAddr;
    logic            rasUnderflow;
    logic [2:0]      rasCount;

    int n_checks = 0;
    int n_errors = 0;

    pc_gen #(
        .XLEN      (XLEN),
        .RESET_VEC (32'h0000_0100),
        .MEM_AW    (13),
        .RAS_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .trapEn       (trapEn),
        .trapVect     (trapVect),
        .jumpEn       (jumpEn),
        .jumpVect     (jumpVect),
        .callEn       (callEn),
        .linkAddr     (linkAddr),
        .retEn        (retEn),
        .pc           (pc),
        .pcForMem     (pcForMem),
        .enA          (enA),
        .misalignErr  (misalignErr),
        .misalignAddr (misalignAddr),
        .rasUnderflow (rasUnderflow),
        .rasCount     (rasCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall    = 1'b0;
        trapEn   = 1'b0;
        jumpEn   = 1'b0;
        callEn   = 1'b0;
        retEn    = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        trapVect = '0;
        jumpVect = '0;
        linkAddr = '0;
        idle_inputs();

        // ---------------- reset and sequential ----------------
        step();
        step();
        check("rst_pc",        pc,           32'h100);
        check("rst_count",     rasCount,     32'd0);
        check("rst_misalign",  misalignErr,  32'd0);
        check("rst_maddr",     misalignAddr, 32'd0);
        check("rst_underflow", rasUnderflow, 32'd0);
        check("rst_enA",       enA,          32'd0);

        reset = 1'b0;
        #1;
        check("first_pc",  pc,       32'h100);
        check("first_mem", pcForMem, 32'h40);
        check("first_enA", enA,      32'd1);
        step();
        check("seq1_pc",  pc,       32'h104);
        check("seq1_mem", pcForMem, 32'h41);
        step();
        check("seq2_pc",  pc,       32'h108);
        check("seq2_mem", pcForMem, 32'h42);

        // ---------------- stall versus jump ----------------
        stall    = 1'b1;
        jumpEn   = 1'b1;
        jumpVect = 32'h2000;
        #1;
        check("stalljump_enA", enA, 32'd1);
        step();
        check("stalljump_pc", pc, 32'h2000);
        jumpEn   = 1'b0;
        callEn   = 1'b1;           // ignored while stalled
        retEn    = 1'b1;
        linkAddr = 32'h999;
        #1;
        check("stall_enA", enA, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc",    pc,       32'h2000);
            check("stall_count", rasCount, 32'd0);
        end
        check("stall_nouflow", rasUnderflow, 32'd0);

        // ---------------- misaligned jump ----------------
        idle_inputs();
        jumpEn   = 1'b1;
        jumpVect = 32'h10;
        step();
        check("jmp10_pc", pc, 32'h10);
        jumpVect = 32'h2002;
        callEn   = 1'b1;           // no RAS change on a rejected jump
        linkAddr = 32'h777;
        step();
        check("mis_pc",    pc,           32'h10);
        check("mis_err",   misalignErr,  32'd1);
        check("mis_addr",  misalignAddr, 32'h2002);
        check("mis_count", rasCount,     32'd0);
        idle_inputs();
        step();
        check("mis_after_pc",   pc,           32'h14);
        check("mis_pulse_end",  misalignErr,  32'd0);
        check("mis_addr_hold",  misalignAddr, 32'h2002);

        // ---------------- RAS overflow ----------------
        callEn   = 1'b1;
        linkAddr = 32'hA0; step();
        check("push1_pc",    pc,       32'h18);
        check("push1_count", rasCount, 32'd1);
        linkAddr = 32'hB0; step();
        check("push2_count", rasCount, 32'd2);
        linkAddr = 32'hC0; step();
        check("push3_count", rasCount, 32'd3);
        linkAddr = 32'hD0; step();
        check("push4_count", rasCount, 32'd4);
        linkAddr = 32'hE0; step();
        check("push5_pc",    pc,       32'h28);
        check("push5_count", rasCount, 32'd4);

        callEn = 1'b0;
        retEn  = 1'b1;
        step();
        check("pop1_pc", pc, 32'hE0);
        check("pop1_count", rasCount, 32'd3);
        step();
        check("pop2_pc", pc, 32'hD0);
        step();
        check("pop3_pc", pc, 32'hC0);
        step();
        check("pop4_pc",    pc,       32'hB0);
        check("pop4_count", rasCount, 32'd0);
        step();
        check("uflow_pc",    pc,           32'hB4);
        check("uflow_pulse", rasUnderflow, 32'd1);
        check("uflow_count", rasCount,     32'd0);
        retEn = 1'b0;
        step();
        check("uflow_end_pc",    pc,           32'hB8);
        check("uflow_pulse_end", rasUnderflow, 32'd0);

        // ---------------- trap flush ----------------
        callEn   = 1'b1;
        linkAddr = 32'h11; step();
        linkAddr = 32'h22; step();
        check("tpush_pc",    pc,       32'hC0);
        check("tpush_count", rasCount, 32'd2);
        callEn   = 1'b1;           // ignored on trap
        retEn    = 1'b1;
        stall    = 1'b1;
        trapEn   = 1'b1;
        trapVect = 32'h303;
        #1;
        check("trap_enA", enA, 32'd1);
        step();
        check("trap_pc",    pc,       32'h300);
        check("trap_count", rasCount, 32'd0);

        // ---------------- combined pop + push ----------------
        idle_inputs();
        callEn   = 1'b1;
        linkAddr = 32'h50;
        step();
        check("c_push_pc",    pc,       32'h304);
        check("c_push_count", rasCount, 32'd1);
        retEn    = 1'b1;
        linkAddr = 32'h60;
        step();
        check("c_swap_pc",    pc,       32'h50);
        check("c_swap_count", rasCount, 32'd1);
        callEn = 1'b0;
        step();
        check("c_ret_pc",    pc,       32'h60);
        check("c_ret_count", rasCount, 32'd0);

        // jump with call pushes, the return is squashed (no underflow)
        jumpEn   = 1'b1;
        jumpVect = 32'h400;
        callEn   = 1'b1;
        linkAddr = 32'h70;
        retEn    = 1'b1;
        step();
        check("jcall_pc",     pc,           32'h400);
        check("jcall_count",  rasCount,     32'd1);
        check("jcall_nouflw", rasUnderflow, 32'd0);

        // ---------------- wrap ----------------
        idle_inputs();
        jumpEn   = 1'b1;
        jumpVect = 32'hFFFF_FFFC;
        step();
        check("wrap_top_pc",  pc,       32'hFFFF_FFFC);
        check("wrap_top_mem", pcForMem, 32'h1FFF);
        jumpEn = 1'b0;
        step();
        check("wrap_pc",  pc,       32'h0);
        check("wrap_mem", pcForMem, 32'h0);

        // ---------------- reset mid-stall / mid-redirect ----------------
        stall    = 1'b1;
        jumpEn   = 1'b1;
        jumpVect = 32'h800;
        reset    = 1'b1;
        #1;
        check("rst2_enA", enA, 32'd0);
        step();
        check("rst2_pc",    pc,       32'h100);
        check("rst2_count", rasCount, 32'd0);
        reset = 1'b0;
        idle_inputs();
        step();
        check("rst2_seq_pc", pc, 32'h104);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
